serial_byte_loader: RTL and testbench

Serial-to-parallel front end for the 8-bit latch register. It accepts one bit per clock over a valid/ready serial interface and assembles WIDTH bits, LSB or MSB first. It then presents the completed word on a valid/ready parallel interface. P_DATA drives the register's D bus, and the P_VALID & P_READY pulse is the register's load enable.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/bit_insert.sv | 44 ++++
 rtl/serial_byte_loader.sv | 202 ++++++++++++++++++++
 tb/tb_serial_byte_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the serial byte loader and the 8-bit latch register
// it feeds.
//   DEFAULT_WIDTH : default word width, common to the loader and the register
//   state_t       : loader FSM state encoding (2 bits)
// -----------------------------------------------------------------------------
package loader_pkg;

  // Word width shared with the downstream 8-bit register.
  localparam int DEFAULT_WIDTH = 32'sd8;

  // Loader FSM states. The 2'b11 encoding is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/bit_insert.sv
// -----------------------------------------------------------------------------
// bit_insert
// Combinational helper that writes one serial bit into the shift vector.
// The bit goes to position cnt (LSB-first) or WIDTH-1-cnt (MSB-first). All
// other positions pass through unchanged.
// Ports:
//   vec      in   WIDTH  current shift vector
//   cnt      in   CNT_W  arrival index of this bit within the word
//   din      in   1      serial data bit
//   vec_next out  WIDTH  vector with the bit inserted
// -----------------------------------------------------------------------------
module bit_insert
  import loader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [CNT_W-1:0] cnt,
  input  logic             din,
  output logic [WIDTH-1:0] vec_next
);

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] pos_s;

  // Map the arrival index onto the physical bit position for the chosen order.
  always_comb begin
    if (MSB_FIRST == 1'b1) begin
      pos_s = LAST_POS - cnt;
    end else begin
      pos_s = cnt;
    end
  end

  // Overwrite only the addressed bit; positions not yet written keep old data.
  always_comb begin
    vec_next        = vec;
    vec_next[pos_s] = din;
  end

endmodule

// File: rtl/serial_byte_loader.sv
// -----------------------------------------------------------------------------
// serial_byte_loader
// Serial-to-parallel front end for the 8-bit latch register. It takes one bit
// per clock over a valid/ready serial port and assembles WIDTH bits, LSB or
// MSB first. The finished word is held on a valid/ready parallel port.
// At integration, P_DATA drives the register's D bus and P_VALID & P_READY
// is its load strobe. RST is shared with the register.
// Ports:
//   CLK       in   1      clock, rising edge
//   RST       in   1      synchronous active-high reset
//   S_DATA    in   1      serial data bit
//   S_VALID   in   1      S_DATA valid
//   S_FIRST   in   1      S_DATA is the first bit of a word
//   S_READY   out  1      a bit is accepted this cycle (registered)
//   P_DATA    out  WIDTH  assembled word, frozen while P_VALID=1
//   P_VALID   out  1      complete word available (registered)
//   P_READY   in   1      downstream takes the word (sampled in HOLD only)
//   BIT_CNT   out  CNT_W  bits accepted in the current word
//   FRAME_ERR out  1      one-cycle pulse on resync or unframed bit
// -----------------------------------------------------------------------------
module serial_byte_loader
  import loader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     S_DATA,
  input  logic                     S_VALID,
  input  logic                     S_FIRST,
  output logic                     S_READY,
  output logic [WIDTH-1:0]         P_DATA,
  output logic                     P_VALID,
  input  logic                     P_READY,
  output logic [$clog2(WIDTH)-1:0] BIT_CNT,
  output logic                     FRAME_ERR
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  // Registered state and outputs
  state_t           state_r;
  logic [WIDTH-1:0] shift_r;
  logic [CNT_W-1:0] cnt_r;
  logic             s_ready_r;
  logic             p_valid_r;
  logic             frame_err_r;

  // Next-cycle values
  state_t           state_s;
  logic [WIDTH-1:0] shift_s;
  logic [CNT_W-1:0] cnt_s;
  logic             s_ready_s;
  logic             p_valid_s;
  logic             frame_err_s;

  // Datapath helpers
  logic             accept_s;
  logic [CNT_W-1:0] ins_cnt_s;
  logic [WIDTH-1:0] ins_vec_s;

  // S_READY is already low in HOLD and in the cycle after reset, so the
  // handshake alone qualifies a bit.
  assign accept_s = S_VALID & s_ready_r;

  // A framing bit always starts a new word at index 0, even on resync.
  always_comb begin
    if (S_FIRST == 1'b1) begin
      ins_cnt_s = ZERO_CNT;
    end else begin
      ins_cnt_s = cnt_r;
    end
  end

  bit_insert #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_bit_insert (
    .vec      (shift_r),
    .cnt      (ins_cnt_s),
    .din      (S_DATA),
    .vec_next (ins_vec_s)
  );

  // State register together with the datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST == 1'b1) begin
      state_r     <= IDLE;
      shift_r     <= {WIDTH{1'b0}};
      cnt_r       <= ZERO_CNT;
      s_ready_r   <= 1'b0;
      p_valid_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      cnt_r       <= cnt_s;
      s_ready_r   <= s_ready_s;
      p_valid_r   <= p_valid_s;
      frame_err_r <= frame_err_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if ((accept_s == 1'b1) && (S_FIRST == 1'b1)) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        // A resync bit keeps us in SHIFT; only the last in-frame bit leaves.
        if ((accept_s == 1'b1) && (S_FIRST == 1'b0) && (cnt_r == LAST_CNT)) begin
          state_s = HOLD;
        end else begin
          state_s = SHIFT;
        end
      end
      HOLD: begin
        if (P_READY == 1'b1) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath updates and next values of the registered outputs.
  always_comb begin
    shift_s     = shift_r;
    cnt_s       = cnt_r;
    frame_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s == 1'b1) begin
          if (S_FIRST == 1'b1) begin
            shift_s = ins_vec_s;
            cnt_s   = ONE_CNT;
          end else begin
            // Unframed bit: dropped, flagged, nothing stored.
            frame_err_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      SHIFT: begin
        if (accept_s == 1'b1) begin
          shift_s = ins_vec_s;
          if (S_FIRST == 1'b1) begin
            // Resync: the partial word is abandoned, this bit is bit 0.
            cnt_s       = ONE_CNT;
            frame_err_s = 1'b1;
          end else if (cnt_r == LAST_CNT) begin
            cnt_s = ZERO_CNT;
          end else begin
            cnt_s = cnt_r + ONE_CNT;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      HOLD: begin
        // Word frozen; serial input ignored.
        shift_s = shift_r;
      end
      default: begin
        cnt_s = ZERO_CNT;
      end
    endcase

    // Handshake flags follow the state we are about to enter, so they can be
    // registered without any combinational input path to the outputs.
    if (state_s == HOLD) begin
      s_ready_s = 1'b0;
      p_valid_s = 1'b1;
    end else begin
      s_ready_s = 1'b1;
      p_valid_s = 1'b0;
    end
  end

  assign S_READY   = s_ready_r;
  assign P_DATA    = shift_r;
  assign P_VALID   = p_valid_r;
  assign BIT_CNT   = cnt_r;
  assign FRAME_ERR = frame_err_r;

endmodule

// File: tb/tb_serial_byte_loader.sv
// Bench for serial_byte_loader. Two instances, one LSB-first and one
// MSB-first, share the same stimulus. A queue-based reference model
// predicts every output each cycle.
module tb_serial_byte_loader;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          CLK = 1'b0;
  logic          RST;
  logic          S_DATA;
  logic          S_VALID;
  logic          S_FIRST;
  logic          P_READY;

  logic          rdy_l, pv_l, fe_l;
  logic [W-1:0]  pd_l;
  logic [CW-1:0] cnt_l;
  logic          rdy_m, pv_m, fe_m;
  logic [W-1:0]  pd_m;
  logic [CW-1:0] cnt_m;

  int checks   = 0;
  int failures = 0;

  // Reference model: bits of the word under assembly, plus the flags the
  // rules imply.
  bit           bq[$];
  bit           m_hold;
  bit           m_rdy;
  bit           m_ferr;
  logic [W-1:0] m_lsb;
  logic [W-1:0] m_msb;

  always #5 CLK = ~CLK;

  serial_byte_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK), .RST(RST), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_FIRST(S_FIRST),
    .S_READY(rdy_l), .P_DATA(pd_l), .P_VALID(pv_l), .P_READY(P_READY),
    .BIT_CNT(cnt_l), .FRAME_ERR(fe_l)
  );

  serial_byte_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .CLK(CLK), .RST(RST), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_FIRST(S_FIRST),
    .S_READY(rdy_m), .P_DATA(pd_m), .P_VALID(pv_m), .P_READY(P_READY),
    .BIT_CNT(cnt_m), .FRAME_ERR(fe_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply the spec rules for one rising edge using the inputs present at it.
  task automatic model_edge();
    bit acc;
    if (RST === 1'b1) begin
      bq.delete();
      m_hold = 1'b0;
      m_rdy  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      acc    = (S_VALID === 1'b1) && m_rdy;
      m_ferr = 1'b0;
      if (m_hold) begin
        if (P_READY === 1'b1) m_hold = 1'b0;
      end else if (acc) begin
        if (S_FIRST === 1'b1) begin
          if (bq.size() > 0) m_ferr = 1'b1;
          bq.delete();
          bq.push_back(S_DATA);
        end else if (bq.size() == 0) begin
          m_ferr = 1'b1;
        end else begin
          bq.push_back(S_DATA);
          if (bq.size() == W) begin
            for (int i = 0; i < W; i++) begin
              m_lsb[i]       = bq[i];
              m_msb[W-1-i]   = bq[i];
            end
            m_hold = 1'b1;
            bq.delete();
          end
        end
      end
      m_rdy = !m_hold;
    end
  endtask

  task automatic compare_all();
    check("s_ready_l", 32'(rdy_l), 32'(m_rdy));
    check("s_ready_m", 32'(rdy_m), 32'(m_rdy));
    check("p_valid_l", 32'(pv_l), 32'(m_hold));
    check("p_valid_m", 32'(pv_m), 32'(m_hold));
    check("frame_err_l", 32'(fe_l), 32'(m_ferr));
    check("frame_err_m", 32'(fe_m), 32'(m_ferr));
    check("bit_cnt_l", 32'(cnt_l), 32'(bq.size()));
    check("bit_cnt_m", 32'(cnt_m), 32'(bq.size()));
    if (m_hold) begin
      check("p_data_l", 32'(pd_l), 32'(m_lsb));
      check("p_data_m", 32'(pd_m), 32'(m_msb));
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic f, input logic d);
    S_VALID = v;
    S_FIRST = f;
    S_DATA  = d;
  endtask

  // Send a whole word, bit i taken from pat[i]; optional idle cycle after each.
  task automatic send_word(input logic [W-1:0] pat, input bit gap);
    for (int i = 0; i < W; i++) begin
      drive(1'b1, (i == 0), pat[i]);
      cycle();
      if (gap) begin
        drive(1'b0, 1'b0, 1'b0);
        cycle();
      end
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] pat;
    RST     = 1'b1;
    P_READY = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    m_lsb = '0;
    m_msb = '0;
    @(negedge CLK);
    cycle();
    cycle();
    check("rst_p_data_l", 32'(pd_l), 32'h0);
    check("rst_p_data_m", 32'(pd_m), 32'h0);
    RST = 1'b0;
    cycle();
    check("rst_release_ready", 32'(rdy_l), 32'h1);

    // LSB-first word, then MSB-first view of the same stream under backpressure.
    send_word(8'h4D, 1'b0);
    check("t1_p_data_l", 32'(pd_l), 32'h4D);
    check("t1_p_valid", 32'(pv_l), 32'h1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 0), 1'b1);
      cycle();
      check("t2_p_data_m", 32'(pd_m), 32'hB2);
      check("t2_s_ready_m", 32'(rdy_m), 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0);
    P_READY = 1'b1;
    cycle();
    check("t2_released", 32'(pv_m), 32'h0);
    P_READY = 1'b0;

    // Resync on the 5th bit of a word.
    pat = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0), pat[i]);
      cycle();
    end
    pat = 8'h1E;
    drive(1'b1, 1'b1, pat[0]);
    cycle();
    check("t3_frame_err", 32'(fe_l), 32'h1);
    check("t3_bit_cnt", 32'(cnt_l), 32'h1);
    for (int i = 1; i < W; i++) begin
      drive(1'b1, 1'b0, pat[i]);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0);
    check("t3_p_data_l", 32'(pd_l), 32'h1E);
    check("t3_p_data_m", 32'(pd_m), 32'h78);
    P_READY = 1'b1;
    cycle();
    P_READY = 1'b0;

    // Three unframed bits in IDLE.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'(i));
      cycle();
      check("t4_frame_err", 32'(fe_l), 32'h1);
      check("t4_p_valid", 32'(pv_l), 32'h0);
      check("t4_bit_cnt", 32'(cnt_l), 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0);
    cycle();

    // Gapped input: 16 cycles for the word.
    send_word(8'h4D, 1'b1);
    check("t5_p_data_l", 32'(pd_l), 32'h4D);
    check("t5_p_valid", 32'(pv_l), 32'h1);
    P_READY = 1'b1;
    cycle();
    P_READY = 1'b0;

    // Reset in SHIFT with BIT_CNT=5, then in HOLD.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 0), 1'b1);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0);
    check("t6_bit_cnt5", 32'(cnt_l), 32'h5);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    check("t6_shift_rst_cnt", 32'(cnt_l), 32'h0);
    check("t6_shift_rst_ready", 32'(rdy_l), 32'h0);
    check("t6_shift_rst_ferr", 32'(fe_l), 32'h0);
    check("t6_shift_rst_pdata", 32'(pd_l), 32'h0);
    cycle();
    send_word(8'hC3, 1'b0);
    check("t6_hold_valid", 32'(pv_l), 32'h1);
    RST     = 1'b1;
    P_READY = 1'b1;
    cycle();
    RST     = 1'b0;
    P_READY = 1'b0;
    check("t6_hold_rst_valid", 32'(pv_m), 32'h0);
    check("t6_hold_rst_pdata", 32'(pd_m), 32'h0);
    check("t6_hold_rst_ferr", 32'(fe_m), 32'h0);
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      S_VALID = ($urandom_range(0, 9) < 7);
      S_FIRST = ($urandom_range(0, 9) < 2);
      S_DATA  = 1'($urandom);
      P_READY = 1'($urandom);
      RST     = ($urandom_range(0, 199) == 0);
      cycle();
    end
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
